// File: rtl/lvg_pkg.sv
// Shared definitions for the lvg_seq matrix unit: opcodes, FSM encoding and
// the flat-bus element offset helper.
package lvg_pkg;

   localparam logic [7:0] OP_NOP      = 8'd0;
   localparam logic [7:0] OP_LOAD_L   = 8'd1;
   localparam logic [7:0] OP_LOAD_R   = 8'd2;
   localparam logic [7:0] OP_LOAD_A   = 8'd3;
   localparam logic [7:0] OP_MATMUL   = 8'd4;
   localparam logic [7:0] OP_MATMAC   = 8'd5;
   localparam logic [7:0] OP_ADD      = 8'd6;
   localparam logic [7:0] OP_HADAMARD = 8'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_EW   = 2'd2
   } state_t;

   // Low bit of element (i,j) in a row-major flattened N x N bus.
   function automatic int elem_lo(input int i, input int j, input int n, input int w);
      return (i * n + j) * w;
   endfunction

endpackage

// File: rtl/lvg_pe.sv
// One result element's multiply-accumulate register; sum is the value the
// accumulator takes on an enabled edge, so the top can capture it directly.
module lvg_pe #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              init_en,
   input  logic [DATA_W-1:0] init,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              en,
   output logic [DATA_W-1:0] sum
);

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] prod;

   // Low DATA_W bits of the product are identical for signed and unsigned.
   assign prod = a * b;
   assign sum  = acc + prod;

   always_ff @(posedge clk) begin
      if (clear) begin
         acc <= '0;
      end else if (init_en) begin
         acc <= init;
      end else if (en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/lvg_seq.sv
// Parametrised N x N matrix unit: loads L/R/A by instruction and produces
// B = L*R, L*R+A, L+R or L.*R with a one-cycle b_valid pulse.
module lvg_seq
   import lvg_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              instr,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [N*N*DATA_W-1:0]   l_flat,
   input  logic [N*N*DATA_W-1:0]   r_flat,
   input  logic [N*N*DATA_W-1:0]   a_flat,
   output logic [N*N*DATA_W-1:0]   b_flat,
   output logic                    b_valid,
   output logic                    busy,
   output logic                    err
);

   localparam int MW = N * N * DATA_W;
   localparam int KW = $clog2(N);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   state_t state;
   state_t state_next;

   logic [MW-1:0] l_reg;
   logic [MW-1:0] r_reg;
   logic [MW-1:0] a_reg;
   logic [MW-1:0] b_reg;
   logic [MW-1:0] mul_flat;
   logic [MW-1:0] ew_flat;
   logic [KW-1:0] k;
   logic          ew_add;

   logic [DATA_W-1:0] l_m [N][N];
   logic [DATA_W-1:0] r_m [N][N];
   logic [DATA_W-1:0] a_m [N][N];

   logic accept;
   logic is_mm;
   logic is_mac;
   logic is_ew;
   logic is_illegal;
   logic mul_start;
   logic mul_last;

   assign accept     = instr_valid && instr_ready;
   assign is_mm      = (instr == OP_MATMUL);
   assign is_mac     = (instr == OP_MATMAC);
   assign is_ew      = (instr == OP_ADD) || (instr == OP_HADAMARD);
   assign is_illegal = (instr > OP_HADAMARD);
   assign mul_start  = accept && (is_mm || is_mac);
   assign mul_last   = (k == K_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (mul_start) begin
               state_next = S_MUL;
            end else if (accept && is_ew) begin
               state_next = S_EW;
            end
         end
         S_MUL:   if (mul_last) state_next = S_IDLE;
         S_EW:    state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Ready is masked by rst so nothing is accepted on a reset edge.
   always_comb begin
      busy        = (state != S_IDLE);
      instr_ready = (state == S_IDLE) && !rst;
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            localparam int LO = elem_lo(gi, gj, N, DATA_W);

            assign l_m[gi][gj] = l_reg[LO +: DATA_W];
            assign r_m[gi][gj] = r_reg[LO +: DATA_W];
            assign a_m[gi][gj] = a_reg[LO +: DATA_W];

            assign ew_flat[LO +: DATA_W] = ew_add ? (l_m[gi][gj] + r_m[gi][gj])
                                                  : (l_m[gi][gj] * r_m[gi][gj]);

            lvg_pe #(.DATA_W(DATA_W)) u_pe (
               .clk     (clk),
               .clear   (rst),
               .init_en (mul_start),
               .init    (is_mac ? a_m[gi][gj] : {DATA_W{1'b0}}),
               .a       (l_m[gi][k]),
               .b       (r_m[k][gj]),
               .en      (state == S_MUL),
               .sum     (mul_flat[LO +: DATA_W])
            );
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         l_reg   <= '0;
         r_reg   <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         k       <= '0;
         ew_add  <= 1'b0;
         b_valid <= 1'b0;
         err     <= 1'b0;
      end else begin
         b_valid <= 1'b0;
         if (accept) begin
            case (instr)
               OP_NOP:      ;
               OP_LOAD_L:   l_reg  <= l_flat;
               OP_LOAD_R:   r_reg  <= r_flat;
               OP_LOAD_A:   a_reg  <= a_flat;
               OP_MATMUL:   k      <= '0;
               OP_MATMAC:   k      <= '0;
               OP_ADD:      ew_add <= 1'b1;
               OP_HADAMARD: ew_add <= 1'b0;
               default:     err    <= 1'b1;
            endcase
         end
         if (state == S_MUL) begin
            if (mul_last) begin
               k       <= '0;
               b_reg   <= mul_flat;
               b_valid <= 1'b1;
            end else begin
               k <= k + 1'b1;
            end
         end
         if (state == S_EW) begin
            b_reg   <= ew_flat;
            b_valid <= 1'b1;
         end
      end
   end

   assign b_flat = b_reg;

endmodule

// File: tb/tb_lvg_seq.sv
// Directed bench for lvg_seq: an N=4 instance for the main scenarios and an
// N=2 instance for the small-dimension case.
module tb_lvg_seq;

   logic         clk;
   logic         rst;
   logic [7:0]   instr;
   logic         instr_valid;
   logic         instr_ready;
   logic [511:0] l_flat, r_flat, a_flat, b_flat;
   logic         b_valid, busy, err;

   logic [7:0]   instr2;
   logic         instr_valid2;
   logic         instr_ready2;
   logic [127:0] l_flat2, r_flat2, a_flat2, b_flat2;
   logic         b_valid2, busy2, err2;

   int checks;
   int errors;

   lvg_seq #(.N(4), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .l_flat      (l_flat),
      .r_flat      (r_flat),
      .a_flat      (a_flat),
      .b_flat      (b_flat),
      .b_valid     (b_valid),
      .busy        (busy),
      .err         (err)
   );

   lvg_seq #(.N(2), .DATA_W(32)) dut2 (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr2),
      .instr_valid (instr_valid2),
      .instr_ready (instr_ready2),
      .l_flat      (l_flat2),
      .r_flat      (r_flat2),
      .a_flat      (a_flat2),
      .b_flat      (b_flat2),
      .b_valid     (b_valid2),
      .busy        (busy2),
      .err         (err2)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] fill4(input logic [31:0] v);
      logic [511:0] f;
      for (int e = 0; e < 16; e++) f[e*32 +: 32] = v;
      return f;
   endfunction

   function automatic logic [127:0] fill2(input logic [31:0] v);
      logic [127:0] f;
      for (int e = 0; e < 4; e++) f[e*32 +: 32] = v;
      return f;
   endfunction

   task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] op);
      instr       = op;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      instr       = 8'd0;
   endtask

   // Issue a compute, wait (bounded) for b_valid and check latency, result,
   // that ready stayed low while busy, and that b_valid is a single pulse.
   task automatic runCompute(input string tag, input logic [7:0] op,
                             input logic [511:0] exp, input int lat_exp);
      int lat;
      logic ready_seen;
      lat        = 0;
      ready_seen = 1'b0;
      applyStimulus(op);
      while (!b_valid && lat < 20) begin
         if (instr_ready) ready_seen = 1'b1;
         tick();
         lat++;
      end
      checkOutput({tag, "_latency"}, 512'(lat), 512'(lat_exp));
      checkOutput({tag, "_ready_low"}, 512'(ready_seen), 512'(0));
      checkOutput({tag, "_ready_at_valid"}, 512'(instr_ready), 512'(1));
      checkOutput({tag, "_b"}, b_flat, exp);
      tick();
      checkOutput({tag, "_pulse"}, 512'(b_valid), 512'(0));
      checkOutput({tag, "_hold"}, b_flat, exp);
   endtask

   initial begin
      logic [511:0] ident, ramp;
      logic         bv_seen;
      int           lat;

      checks       = 0;
      errors       = 0;
      clk          = 1'b0;
      rst          = 1'b1;
      instr        = 8'd0;
      instr_valid  = 1'b0;
      l_flat       = '0;
      r_flat       = '0;
      a_flat       = '0;
      instr2       = 8'd0;
      instr_valid2 = 1'b0;
      l_flat2      = '0;
      r_flat2      = '0;
      a_flat2      = '0;

      tick();
      tick();
      checkOutput("rst_ready", 512'(instr_ready), 512'(0));
      checkOutput("rst_b", b_flat, '0);
      checkOutput("rst_flags", 512'({b_valid, busy, err}), 512'(0));
      rst = 1'b0;
      #1;
      checkOutput("ready_after_rst", 512'(instr_ready), 512'(1));

      r_flat = fill4(32'h1);
      applyStimulus(8'd2);
      l_flat = fill4(32'h1);
      applyStimulus(8'd1);
      runCompute("matmul_ones", 8'd4, fill4(32'h4), 4);

      a_flat = fill4(32'h1);
      applyStimulus(8'd3);
      runCompute("matmac_ones", 8'd5, fill4(32'h5), 4);

      ident = '0;
      ramp  = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ramp[(i*4+j)*32 +: 32] = 32'(i*4 + j);
            if (i == j) ident[(i*4+j)*32 +: 32] = 32'h1;
         end
      end
      l_flat = ident;
      applyStimulus(8'd1);
      r_flat = ramp;
      applyStimulus(8'd2);
      l_flat = '0;
      r_flat = '0;
      runCompute("matmul_identity", 8'd4, ramp, 4);

      l_flat = fill4(32'h3);
      applyStimulus(8'd1);
      r_flat = fill4(32'hFFFFFFFF);
      applyStimulus(8'd2);
      runCompute("add_wrap", 8'd6, fill4(32'h2), 1);
      runCompute("hadamard", 8'd7, fill4(32'hFFFFFFFD), 1);

      l_flat = fill4(32'h00010000);
      applyStimulus(8'd1);
      r_flat = fill4(32'h00010000);
      applyStimulus(8'd2);
      runCompute("matmul_trunc", 8'd4, fill4(32'h0), 4);

      applyStimulus(8'd9);
      checkOutput("illegal_err", 512'(err), 512'(1));
      checkOutput("illegal_no_valid", 512'({b_valid, busy}), 512'(0));
      tick();
      checkOutput("illegal_err_sticky", 512'(err), 512'(1));

      l_flat = fill4(32'h1);
      applyStimulus(8'd1);
      r_flat = fill4(32'h1);
      applyStimulus(8'd2);
      runCompute("matmul_after_err", 8'd4, fill4(32'h4), 4);
      checkOutput("err_still_set", 512'(err), 512'(1));

      // MATMUL held valid through a busy period: the second copy may only be
      // taken on the edge that closes the b_valid cycle.
      instr       = 8'd4;
      instr_valid = 1'b1;
      tick();
      lat = 0;
      while (!b_valid && lat < 20) begin
         tick();
         lat++;
      end
      checkOutput("held_first_latency", 512'(lat), 512'(4));
      checkOutput("held_ready_at_valid", 512'(instr_ready), 512'(1));
      tick();
      instr_valid = 1'b0;
      instr       = 8'd0;
      checkOutput("held_accepted", 512'({busy, b_valid}), 512'(2'b10));
      lat = 0;
      while (!b_valid && lat < 20) begin
         tick();
         lat++;
      end
      checkOutput("held_second_latency", 512'(lat), 512'(4));
      checkOutput("held_second_b", b_flat, fill4(32'h4));
      tick();

      applyStimulus(8'd4);
      tick();
      tick();
      rst = 1'b1;
      tick();
      checkOutput("midrst_ready", 512'(instr_ready), 512'(0));
      checkOutput("midrst_flags", 512'({b_valid, busy, err}), 512'(0));
      checkOutput("midrst_b", b_flat, '0);
      rst = 1'b0;
      bv_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (b_valid) bv_seen = 1'b1;
         tick();
      end
      checkOutput("midrst_no_valid", 512'(bv_seen), 512'(0));
      checkOutput("midrst_b_still_zero", b_flat, '0);

      l_flat2      = fill2(32'h1);
      r_flat2      = fill2(32'h1);
      instr_valid2 = 1'b1;
      instr2       = 8'd2;
      tick();
      instr2 = 8'd1;
      tick();
      instr2 = 8'd4;
      tick();
      instr_valid2 = 1'b0;
      instr2       = 8'd0;
      lat = 0;
      while (!b_valid2 && lat < 20) begin
         tick();
         lat++;
      end
      checkOutput("n2_latency", 512'(lat), 512'(2));
      checkOutput("n2_b", 512'(b_flat2), 512'(fill2(32'h2)));
      checkOutput("n2_ready", 512'(instr_ready2), 512'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lvg_seq.md
# lvg_seq

Parametrised successor to the fixed 4x4 `lvg` matrix unit. It holds three N×N operand matrices (L, R, A) loaded by instruction and computes one of four matrix operations into result matrix B. Operation is on signed two's-complement integers of width DATA_W. Instructions use a ready/valid handshake, and B is qualified by a one-cycle `b_valid` pulse. It sits between the instruction sequencer and the result writeback path.

## Interface
- `N`, default 4: matrix dimension, N ≥ 2.
- `DATA_W`, default 32: element width in bits.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `instr` input, 8 bits: opcode.
- `instr_valid` input, 1 bit: `instr` is presented.
- `instr_ready` output, 1 bit: the block accepts an instruction this cycle.
- `l_flat`, `r_flat`, `a_flat` input, N·N·DATA_W bits each: operand buses, sampled only at a load accept.
- `b_flat` output, N·N·DATA_W bits: result matrix, registered.
- `b_valid` output, 1 bit: one-cycle pulse when `b_flat` is updated.
- `busy` output, 1 bit: the block is in a compute state.
- `err` output, 1 bit: sticky; set when an illegal opcode is accepted.
- Flattening for all matrix buses: element (i,j), zero-based and row-major, occupies bits [(i·N+j+1)·DATA_W−1 : (i·N+j)·DATA_W].

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LOAD_L.
  - 2 LOAD_R.
  - 3 LOAD_A.
  - 4 MATMUL: B=L·R.
  - 5 MATMAC: B=L·R+A.
  - 6 ADD: B=L+R.
  - 7 HADAMARD: B=L∘R.
  - 8–255 illegal.
- Accept condition: `instr_valid && instr_ready` at a rising edge.
- States:
  - IDLE: `instr_ready`=1.
  - MUL: `busy`=1, `instr_ready`=0.
  - EW: `busy`=1, `instr_ready`=0.
- Accept in IDLE:
  - Load opcode: the matching operand register captures its bus; state stays IDLE.
  - NOP: no effect.
  - Illegal opcode: `err`←1; state stays IDLE; no `b_valid`.
  - MATMUL: accumulators ← 0, k←0, go to MUL.
  - MATMAC: accumulators ← A, k←0, go to MUL.
  - ADD or HADAMARD: go to EW.
- MUL: each cycle, acc[i][j] += L[i][k]·R[k][j] for all i,j in parallel; k increments each cycle.
  - On the edge that processes k=N−1, B ← final accumulators, `b_valid`←1, state → IDLE.
- EW: one edge computes B elementwise, sets `b_valid`←1, and returns to IDLE.
- Compute uses only the stored L/R/A registers. Bus values during compute are ignored.
- Arithmetic: each product is truncated to its low DATA_W bits. All sums wrap modulo 2^DATA_W. There is no saturation and no overflow flag.
- `b_flat` holds its value until the next `b_valid`.
- An instruction presented while busy is not lost; it stays pending until `instr_ready` returns.

## Timing
- Reset, taking effect at the edge where `rst`=1:
  - L, R, A, B, accumulators, k ← 0.
  - `b_valid`, `busy`, `err` ← 0.
  - State ← IDLE.
  - `instr_ready` ← 0 while `rst` is high, and 1 in the first cycle after `rst` is deasserted.
- Load: operand is visible to a compute accepted at the very next edge.
- MATMUL/MATMAC latency: accept at edge E0, `b_valid` high in the cycle after edge EN (N edges later).
  - `instr_ready` is low from E0 to EN and high again in the same cycle as `b_valid`.
  - Back-to-back throughput is one compute per N+1 cycles.
- ADD/HADAMARD latency: `b_valid` high in the cycle after E1. Throughput is one compute per 2 cycles.
- Reset mid-compute: the operation is abandoned, with no `b_valid` pulse; all registers are cleared as above.
- `b_valid` and `instr_ready` may both be high in the same cycle. A compute accepted in that cycle starts normally.

## Structure
- Package `lvg_pkg`: opcode constants, state encoding, and an index helper for the flat-bus offset.
- Sub-module `lvg_pe`: one element's DATA_W multiply-accumulate register.
  - Inputs: clear, load-init value, a, b, enable.
  - `lvg_seq` instantiates N·N of them in a generate loop.
  - The elementwise path sits in the top level.
- Top level also contains: FSM, k counter (width $clog2(N)), and the operand and result registers.

## Test plan
All scenarios use N=4, DATA_W=32 unless stated.
- Reset, LOAD_R with all 32'h1, LOAD_L with all 32'h1, then MATMUL → all B=32'h4. `b_valid` is a single pulse 4 edges after accept, with `instr_ready` low for exactly those 4 cycles.
- Scenario 1 state plus LOAD_A with all 32'h1, then MATMAC → all B=32'h5. Also: L=identity, R=row-major 0..15, MATMUL → B=R.
- L all 32'h3, R all 32'hFFFFFFFF:
  - ADD → all B=32'h2.
  - HADAMARD → all B=32'hFFFFFFFD.
  - Each has 1-edge latency.
- L=R all 32'h00010000, MATMUL → all B=0, showing product truncation and wrap.
- Opcode 8'd9 accepted → `err`=1 and stays set; no `b_valid`; a following MATMUL still runs. MATMUL held valid during busy → accepted exactly at the `b_valid` cycle.
- `rst` asserted 2 cycles into a MATMUL → no `b_valid`, B=0, `err`=0. Repeat scenario 1 with N=2 → B all 32'h2 after 2 edges.
